disp_timing_gen: RTL and testbench

Parametrised display-controller timing generator. It produces VSYNC, HSYNC, DATA_ENABLE and DATA for the DSI display-controller input path, and is the generator the cnt_drv/cnt_mon agents drive against and check. Pixels are pulled from an upstream valid/ready stream. Timing, sync polarity and pixel width are configurable; runtime adds pixel-format packing, underflow handling and graceful stop.

---
 rtl/disp_timing_gen.sv | 135 +++++++++++++
 tb/tb_disp_timing_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_timing_gen.sv
// Display timing generator: VSYNC/HSYNC/DATA_ENABLE/DATA from a valid/ready pixel stream,
// with per-frame pixel-format packing, sticky underflow flag and stop at frame end.
module disp_timing_gen #(
    parameter int               PIX_W           = 24,
    parameter int               H_ACTIVE        = 640,
    parameter int               H_FP            = 16,
    parameter int               H_SYNC          = 96,
    parameter int               H_BP            = 48,
    parameter int               V_ACTIVE        = 480,
    parameter int               V_FP            = 10,
    parameter int               V_SYNC          = 2,
    parameter int               V_BP            = 33,
    parameter int               HS_POL          = 1,
    parameter int               VS_POL          = 1,
    parameter logic [PIX_W-1:0] UNDERFLOW_COLOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       pix_fmt,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             clr_status,
    output logic             VSYNC,
    output logic             HSYNC,
    output logic             DATA_ENABLE,
    output logic [PIX_W-1:0] DATA,
    output logic             frame_start,
    output logic             underflow,
    output logic [15:0]      frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    logic [HW-1:0]    hcnt;
    logic [VW-1:0]    vcnt;
    logic [1:0]       fmt_q;
    logic [1:0]       fmt_sel;
    logic             active;
    logic             hact;
    logic             vact;
    logic             hs;
    logic             vs;
    logic             h_last;
    logic             v_last;
    logic             frame_first;
    logic             frame_last;
    logic [PIX_W-1:0] packed_pix;

    always_comb begin
        active      = (state != IDLE);
        hact        = int'(hcnt) < H_ACTIVE;
        vact        = int'(vcnt) < V_ACTIVE;
        hs          = (int'(hcnt) >= H_ACTIVE + H_FP) && (int'(hcnt) < H_ACTIVE + H_FP + H_SYNC);
        vs          = (int'(vcnt) >= V_ACTIVE + V_FP) && (int'(vcnt) < V_ACTIVE + V_FP + V_SYNC);
        h_last      = int'(hcnt) == H_TOTAL - 1;
        v_last      = int'(vcnt) == V_TOTAL - 1;
        frame_first = (hcnt == '0) && (vcnt == '0);
        frame_last  = h_last && v_last;
        pix_ready   = active && hact && vact;
        // The format sampled on the first frame cycle already applies to that cycle's pixel
        fmt_sel     = (active && frame_first) ? pix_fmt : fmt_q;
        packed_pix  = pix_data;
        if (PIX_W == 24) begin
            case (fmt_sel)
                2'b01:   packed_pix = pix_data & PIX_W'(24'hFCFCFC);
                2'b10:   packed_pix = pix_data & PIX_W'(24'hF8FCF8);
                default: packed_pix = pix_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            fmt_q       <= 2'b00;
            HSYNC       <= ~HS_ON;
            VSYNC       <= ~VS_ON;
            DATA_ENABLE <= 1'b0;
            DATA        <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    hcnt <= '0;
                    vcnt <= '0;
                    if (en) state <= RUN;
                end
                RUN, DRAIN: begin
                    if (h_last) begin
                        hcnt <= '0;
                        vcnt <= v_last ? '0 : vcnt + 1'b1;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                    if (state == RUN) begin
                        if (!en) state <= DRAIN;
                    end else if (en) begin
                        state <= RUN;
                    end else if (frame_last) begin
                        state <= IDLE;
                    end
                    if (frame_last) frame_cnt <= frame_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase

            if ((state == IDLE && en) || (active && frame_first)) fmt_q <= pix_fmt;

            DATA_ENABLE <= pix_ready;
            HSYNC       <= (active && hs) ? HS_ON : ~HS_ON;
            VSYNC       <= (active && vs) ? VS_ON : ~VS_ON;
            frame_start <= active && frame_first;
            if (pix_ready) DATA <= pix_valid ? packed_pix : UNDERFLOW_COLOR;
            else           DATA <= '0;

            if (pix_ready && !pix_valid) underflow <= 1'b1;
            else if (clr_status)         underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_disp_timing_gen.sv
// Directed bench for disp_timing_gen on an 8x6 frame, checking a positive- and a negative-sync instance.
module tb_disp_timing_gen;

    localparam logic [23:0] UFC = 24'hA5C33C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en, clr_status, pix_valid;
    logic [1:0]  pix_fmt;
    logic [23:0] pix_data;

    logic        pix_ready, VSYNC, HSYNC, DATA_ENABLE, frame_start, underflow;
    logic [23:0] DATA;
    logic [15:0] frame_cnt;
    logic        n_ready, n_vs, n_hs, n_de, n_fs, n_uf;
    logic [23:0] n_data;
    logic [15:0] n_fcnt;

    int checks = 0;
    int errors = 0;

    typedef enum {M_IDLE, M_RUN, M_DRAIN} mode_t;
    mode_t       mode;
    int          h, v;
    logic [1:0]  fmt_m;
    logic        uf_m;
    logic [15:0] fcnt_m;
    logic [15:0] fc_exp;
    bit          auto_inc;

    disp_timing_gen #(
        .PIX_W(24), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .UNDERFLOW_COLOR(UFC)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pix_fmt(pix_fmt), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .clr_status(clr_status),
        .VSYNC(VSYNC), .HSYNC(HSYNC), .DATA_ENABLE(DATA_ENABLE), .DATA(DATA),
        .frame_start(frame_start), .underflow(underflow), .frame_cnt(frame_cnt)
    );

    disp_timing_gen #(
        .PIX_W(24), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .UNDERFLOW_COLOR(UFC)
    ) dut_n (
        .clk(clk), .rst(rst), .en(en), .pix_fmt(pix_fmt), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(n_ready), .clr_status(clr_status),
        .VSYNC(n_vs), .HSYNC(n_hs), .DATA_ENABLE(n_de), .DATA(n_data),
        .frame_start(n_fs), .underflow(n_uf), .frame_cnt(n_fcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pack(input logic [23:0] d, input logic [1:0] f);
        case (f)
            2'b01:   return d & 24'hFCFCFC;
            2'b10:   return d & 24'hF8FCF8;
            default: return d;
        endcase
    endfunction

    task automatic reset_model();
        mode   = M_IDLE;
        h      = 0;
        v      = 0;
        fmt_m  = 2'b00;
        uf_m   = 1'b0;
        fcnt_m = 16'd0;
    endtask

    // Expectations come from the pre-edge position and inputs; outputs are checked 1 ns after the edge.
    task automatic step();
        logic        run, e_rdy, e_hs, e_vs, e_fs;
        logic [1:0]  f;
        logic [23:0] e_data;
        bit          last;
        run    = (mode != M_IDLE);
        e_rdy  = run && h < 4 && v < 3;
        e_hs   = run && (h == 5 || h == 6);
        e_vs   = run && v == 4;
        e_fs   = run && h == 0 && v == 0;
        f      = (run && h == 0 && v == 0) ? pix_fmt : fmt_m;
        e_data = !e_rdy ? 24'h0 : (pix_valid ? pack(pix_data, f) : UFC);
        chk("pix_ready", {31'b0, pix_ready}, {31'b0, e_rdy});
        chk("n_pix_ready", {31'b0, n_ready}, {31'b0, e_rdy});

        if (e_rdy && !pix_valid) uf_m = 1'b1;
        else if (clr_status)     uf_m = 1'b0;
        if (!run) begin
            if (en) begin
                mode  = M_RUN;
                fmt_m = pix_fmt;
            end
        end else begin
            if (h == 0 && v == 0) fmt_m = pix_fmt;
            last = (h == 7 && v == 5);
            if (last) fcnt_m = fcnt_m + 16'd1;
            h = (h + 1) % 8;
            if (h == 0) v = (v + 1) % 6;
            if (mode == M_RUN) begin
                if (!en) mode = M_DRAIN;
            end else if (en) begin
                mode = M_RUN;
            end else if (last) begin
                mode = M_IDLE;
            end
        end

        @(posedge clk);
        #1;
        chk("DATA_ENABLE", {31'b0, DATA_ENABLE}, {31'b0, e_rdy});
        chk("HSYNC", {31'b0, HSYNC}, {31'b0, e_hs});
        chk("VSYNC", {31'b0, VSYNC}, {31'b0, e_vs});
        chk("n_HSYNC", {31'b0, n_hs}, {31'b0, !e_hs});
        chk("n_VSYNC", {31'b0, n_vs}, {31'b0, !e_vs});
        chk("DATA", {8'b0, DATA}, {8'b0, e_data});
        chk("n_DATA", {8'b0, n_data}, {8'b0, e_data});
        chk("n_DATA_ENABLE", {31'b0, n_de}, {31'b0, e_rdy});
        chk("frame_start", {31'b0, frame_start}, {31'b0, e_fs});
        chk("underflow", {31'b0, underflow}, {31'b0, uf_m});
        chk("frame_cnt", {16'b0, frame_cnt}, {16'b0, fcnt_m});
        if (auto_inc && e_rdy) pix_data = pix_data + 24'd1;
    endtask

    task automatic goto(input int th, input int tv);
        int n;
        n = 0;
        while (!(mode != M_IDLE && h == th && v == tv) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            errors++;
            $error("FAIL goto_timeout observed=%0d,%0d expected=%0d,%0d", h, v, th, tv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_HSYNC"}, {31'b0, HSYNC}, 32'd0);
        chk({tag, "_VSYNC"}, {31'b0, VSYNC}, 32'd0);
        chk({tag, "_n_HSYNC"}, {31'b0, n_hs}, 32'd1);
        chk({tag, "_n_VSYNC"}, {31'b0, n_vs}, 32'd1);
        chk({tag, "_DATA_ENABLE"}, {31'b0, DATA_ENABLE}, 32'd0);
        chk({tag, "_DATA"}, {8'b0, DATA}, 32'd0);
        chk({tag, "_pix_ready"}, {31'b0, pix_ready}, 32'd0);
        chk({tag, "_frame_start"}, {31'b0, frame_start}, 32'd0);
        chk({tag, "_underflow"}, {31'b0, underflow}, 32'd0);
        chk({tag, "_frame_cnt"}, {16'b0, frame_cnt}, 32'd0);
    endtask

    initial begin
        en = 1'b0; clr_status = 1'b0; pix_valid = 1'b0; pix_fmt = 2'b00; pix_data = 24'd0;
        auto_inc = 1'b0;
        reset_model();
        #1 rst = 1'b0;
        #2 chk_reset_outputs("reset");

        // Basic timing with an incrementing pixel stream
        en = 1'b1; pix_valid = 1'b1; pix_data = 24'd1; auto_inc = 1'b1;
        #9 rst = 1'b1;
        repeat (49) step();
        chk("first_frame_cnt", {16'b0, frame_cnt}, 32'd1);
        repeat (48) step();
        chk("second_frame_cnt", {16'b0, frame_cnt}, 32'd2);

        // Format packing, latched per frame
        auto_inc = 1'b0; pix_data = 24'hFFFFFF; pix_fmt = 2'b10;
        goto(0, 0);
        step();
        chk("fmt565", {8'b0, DATA}, {8'b0, 24'hF8FCF8});
        goto(2, 1);
        pix_fmt = 2'b01;
        step();
        chk("fmt_hold_mid_frame", {8'b0, DATA}, {8'b0, 24'hF8FCF8});
        goto(0, 0);
        step();
        chk("fmt666", {8'b0, DATA}, {8'b0, 24'hFCFCFC});
        pix_fmt = 2'b11;
        goto(0, 0);
        step();
        chk("fmt11_as_888", {8'b0, DATA}, {8'b0, 24'hFFFFFF});
        pix_fmt = 2'b00;

        // Underflow: set, sticky, clear, set-wins
        pix_data = 24'h123456;
        goto(1, 0);
        pix_valid = 1'b0;
        step();
        chk("uf_color", {8'b0, DATA}, {8'b0, UFC});
        chk("uf_de", {31'b0, DATA_ENABLE}, 32'd1);
        chk("uf_flag", {31'b0, underflow}, 32'd1);
        pix_valid = 1'b1;
        repeat (60) step();
        chk("uf_sticky", {31'b0, underflow}, 32'd1);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("uf_cleared", {31'b0, underflow}, 32'd0);
        goto(1, 0);
        pix_valid = 1'b0; clr_status = 1'b1;
        step();
        chk("uf_set_wins", {31'b0, underflow}, 32'd1);
        pix_valid = 1'b1; clr_status = 1'b0;
        step();

        // Graceful stop, then resume during drain
        goto(2, 1);
        fc_exp = fcnt_m + 16'd1;
        en = 1'b0;
        for (int i = 0; i < 100 && mode != M_IDLE; i++) step();
        chk("drain_frame_cnt", {16'b0, frame_cnt}, {16'b0, fc_exp});
        repeat (5) step();
        chk("idle_HSYNC", {31'b0, HSYNC}, 32'd0);
        chk("idle_n_HSYNC", {31'b0, n_hs}, 32'd1);
        chk("idle_pix_ready", {31'b0, pix_ready}, 32'd0);
        chk("idle_frame_cnt", {16'b0, frame_cnt}, {16'b0, fc_exp});
        en = 1'b1;
        goto(2, 1);
        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
        repeat (60) step();

        // Asynchronous reset mid-line, during HSYNC and during active video
        goto(6, 0);
        chk("hs_before_rst", {31'b0, HSYNC}, 32'd1);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("async_rst_hs");
        #2 rst = 1'b1;
        reset_model();
        goto(3, 0);
        chk("de_before_rst", {31'b0, DATA_ENABLE}, 32'd1);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("async_rst_de");
        #2 rst = 1'b1;
        reset_model();
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
